maxpool2_unit: RTL and testbench

2x2 stride-2 pooling stage that sits directly downstream of the convolution block in the LeNet5 pipeline. It reads IFM_DEPTH feature maps of IFM_SIZE x IFM_SIZE from the ping-pong memory that the convolution stage has just filled, reduces each 2x2 window to one value, and writes IFM_DEPTH maps of (IFM_SIZE/2)^2 into the next stage's memory. It uses the same start/end handshake as every other stage on both sides.

---
 rtl/maxpool2_unit.sv | 191 +++++++++++++++++++
 tb/tb_maxpool2_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2_unit.sv
// 2x2 stride-2 pooling stage with start/end handshakes on both memory sides.
// Define POOL_AVG_EN for average pooling; the default build does signed max pooling.
module maxpool2_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 28,
  parameter int IFM_DEPTH        = 6,
  parameter int OFM_SIZE         = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE),
  parameter int SEL_BITS         = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_from_previous,
  output logic                               end_to_previous,
  input  logic                               end_from_next,
  output logic                               start_to_next,
  output logic                               ifm_enable_read,
  output logic [SEL_BITS-1:0]                ifm_sel_read,
  output logic [ADDRESS_SIZE_IFM-1:0]        ifm_address_read,
  input  logic signed [DATA_WIDTH-1:0]       ifm_data_in,
  output logic                               ofm_enable_write,
  output logic [SEL_BITS-1:0]                ofm_sel_write,
  output logic [ADDRESS_SIZE_OFM-1:0]        ofm_address_write,
  output logic signed [DATA_WIDTH-1:0]       ofm_data_out
);

  if ((IFM_SIZE % 2) != 0) begin : g_size_check
    $error("maxpool2_unit: IFM_SIZE must be even");
  end

  localparam int CNT_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
`ifdef POOL_AVG_EN
  localparam int POOL_W = DATA_WIDTH + 2;

  function automatic logic signed [POOL_W-1:0] pool_step(
    input logic signed [POOL_W-1:0] acc, input logic signed [DATA_WIDTH-1:0] d, input logic first);
    logic signed [POOL_W-1:0] d_ext;
    d_ext = {{2{d[DATA_WIDTH-1]}}, d};
    return first ? d_ext : acc + d_ext;
  endfunction

  // Arithmetic shift divides by four rounding toward -inf.
  function automatic logic signed [DATA_WIDTH-1:0] pool_final(
    input logic signed [POOL_W-1:0] acc, input logic signed [DATA_WIDTH-1:0] d);
    logic signed [POOL_W-1:0] sum;
    sum = acc + {{2{d[DATA_WIDTH-1]}}, d};
    sum = sum >>> 2;
    return sum[DATA_WIDTH-1:0];
  endfunction
`else
  localparam int POOL_W = DATA_WIDTH;

  function automatic logic signed [POOL_W-1:0] pool_step(
    input logic signed [POOL_W-1:0] acc, input logic signed [DATA_WIDTH-1:0] d, input logic first);
    return (first || (d > acc)) ? d : acc;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] pool_final(
    input logic signed [POOL_W-1:0] acc, input logic signed [DATA_WIDTH-1:0] d);
    return (d > acc) ? d : acc;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t                    state;
  logic [1:0]                k;
  logic [CNT_W-1:0]          col;
  logic [CNT_W-1:0]          row;
  logic [2:0]                drain_cnt;
  logic                      start_pending;
  logic                      last_read;
  logic                      go_read;
  int                        row_i;
  int                        col_i;
  logic                      vld_p1;
  logic [1:0]                k_p1;
  logic signed [POOL_W-1:0]  max_reg;

  always_comb begin
    last_read = (k == 2'd3) && (col == CNT_W'(OFM_SIZE - 1)) && (row == CNT_W'(OFM_SIZE - 1))
             && (ifm_sel_read == SEL_BITS'(IFM_DEPTH - 1));
    go_read   = ((state == IDLE) && start_from_previous)
             || ((state == DONE) && start_to_next && (start_pending || start_from_previous));
    row_i     = 2 * int'(row) + int'(k[1]);
    col_i     = 2 * int'(col) + int'(k[0]);
    ifm_address_read = ADDRESS_SIZE_IFM'(row_i * IFM_SIZE + col_i);
  end

  // Stage p0: control FSM and read-address generation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      end_to_previous <= 1'b1;
      start_to_next   <= 1'b0;
      start_pending   <= 1'b0;
      ifm_enable_read <= 1'b0;
      ifm_sel_read    <= '0;
      k               <= '0;
      col             <= '0;
      row             <= '0;
      drain_cnt       <= '0;
    end else begin
      start_to_next <= 1'b0;
      if (go_read) begin
        state           <= READ;
        end_to_previous <= 1'b0;
        start_pending   <= 1'b0;
        ifm_enable_read <= 1'b1;
        ifm_sel_read    <= '0;
        k               <= '0;
        col             <= '0;
        row             <= '0;
        drain_cnt       <= '0;
      end else begin
        case (state)
          READ: begin
            if (ifm_enable_read) begin
              k <= k + 2'd1;
              if (k == 2'd3) begin
                if (col == CNT_W'(OFM_SIZE - 1)) begin
                  col <= '0;
                  if (row == CNT_W'(OFM_SIZE - 1)) begin
                    row <= '0;
                    ifm_sel_read <= (ifm_sel_read == SEL_BITS'(IFM_DEPTH - 1)) ? '0 : ifm_sel_read + 1'b1;
                  end else begin
                    row <= row + 1'b1;
                  end
                end else begin
                  col <= col + 1'b1;
                end
              end
              if (last_read) begin
                ifm_enable_read <= 1'b0;
                drain_cnt       <= 3'd4;
              end
            end else if (drain_cnt != 3'd0) begin
              drain_cnt <= drain_cnt - 3'd1;
            end else begin
              // Pipeline has retired the final write; hand the output memory over.
              state           <= DONE;
              end_to_previous <= 1'b1;
              start_to_next   <= end_from_next;
            end
          end
          DONE: begin
            if (start_to_next) begin
              state <= IDLE;
            end else begin
              if (start_from_previous) start_pending <= 1'b1;
              if (end_from_next) start_to_next <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p1: read data returns; pooled result registers into the write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1            <= 1'b0;
      k_p1              <= '0;
      max_reg           <= '0;
      ofm_enable_write  <= 1'b0;
      ofm_data_out      <= '0;
      ofm_address_write <= '0;
      ofm_sel_write     <= '0;
    end else begin
      vld_p1           <= ifm_enable_read;
      k_p1             <= k;
      ofm_enable_write <= vld_p1 && (k_p1 == 2'd3);
      if (vld_p1) max_reg <= pool_step(max_reg, ifm_data_in, k_p1 == 2'd0);
      if (vld_p1 && (k_p1 == 2'd3)) ofm_data_out <= pool_final(max_reg, ifm_data_in);
      if (go_read) begin
        ofm_address_write <= '0;
        ofm_sel_write     <= '0;
      end else if (ofm_enable_write) begin
        if (ofm_address_write == ADDRESS_SIZE_OFM'(OFM_SIZE * OFM_SIZE - 1)) begin
          ofm_address_write <= '0;
          ofm_sel_write <= (ofm_sel_write == SEL_BITS'(IFM_DEPTH - 1)) ? '0 : ofm_sel_write + 1'b1;
        end else begin
          ofm_address_write <= ofm_address_write + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2_unit.sv
// Directed bench for maxpool2_unit: a 4x4x2 instance for handshake/reset corner cases
// and a default-parameter instance run against a reference pooling model.
module tb_maxpool2_unit;
`ifdef POOL_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               s_start, s_enf, s_etp, s_stn, s_ren, s_wen;
  logic [0:0]         s_rsel, s_wsel;
  logic [3:0]         s_raddr;
  logic [1:0]         s_waddr;
  logic signed [31:0] s_din, s_dout;

  logic               b_start, b_enf, b_etp, b_stn, b_ren, b_wen;
  logic [2:0]         b_rsel, b_wsel;
  logic [9:0]         b_raddr;
  logic [7:0]         b_waddr;
  logic signed [31:0] b_din, b_dout;

  maxpool2_unit #(.IFM_SIZE(4), .IFM_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .start_from_previous(s_start), .end_to_previous(s_etp),
    .end_from_next(s_enf), .start_to_next(s_stn),
    .ifm_enable_read(s_ren), .ifm_sel_read(s_rsel), .ifm_address_read(s_raddr), .ifm_data_in(s_din),
    .ofm_enable_write(s_wen), .ofm_sel_write(s_wsel), .ofm_address_write(s_waddr), .ofm_data_out(s_dout)
  );

  maxpool2_unit u_big (
    .clk(clk), .reset(reset),
    .start_from_previous(b_start), .end_to_previous(b_etp),
    .end_from_next(b_enf), .start_to_next(b_stn),
    .ifm_enable_read(b_ren), .ifm_sel_read(b_rsel), .ifm_address_read(b_raddr), .ifm_data_in(b_din),
    .ofm_enable_write(b_wen), .ofm_sel_write(b_wsel), .ofm_address_write(b_waddr), .ofm_data_out(b_dout)
  );

  logic [31:0] s_mem [0:1][0:15];
  logic [31:0] b_mem [0:5][0:783];
  always @(posedge clk) if (s_ren) s_din <= s_mem[s_rsel][s_raddr];
  always @(posedge clk) if (b_ren) b_din <= b_mem[b_rsel][b_raddr];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, w_n, p_n, p_cyc, rd_cyc, rd0;
  int w_sel [64], w_addr [64], w_cyc [64];
  logic [31:0] w_data [64];
  logic [31:0] exp_a [8], exp_b [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (s_wen && w_n < 64) begin
      w_sel[w_n] = int'(s_wsel); w_addr[w_n] = int'(s_waddr);
      w_data[w_n] = s_dout; w_cyc[w_n] = cyc; w_n++;
    end
    if (s_stn) begin p_n++; p_cyc = cyc; end
    if (!s_etp) rd_cyc++;
  endtask

  task automatic clear_log();
    w_n = 0; p_n = 0; p_cyc = 0; rd_cyc = 0;
    for (int i = 0; i < 64; i++) begin w_sel[i] = 0; w_addr[i] = 0; w_cyc[i] = 0; w_data[i] = '0; end
  endtask

  task automatic wait_pulse(input string tag);
    int g = 0;
    while (p_n == 0 && g < 200) begin tick(); g++; end
    check({tag, "_pulse_seen"}, 64'(p_n != 0), 64'(1));
  endtask

  task automatic check_frame(input string tag, input logic [31:0] e [8]);
    check({tag, "_wr_count"}, 64'(w_n), 64'(8));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_wr%0d", tag, i),
            {16'd0, 8'(w_sel[i]), 8'(w_addr[i]), w_data[i]},
            {16'd0, 8'(i / 4), 8'(i % 4), e[i]});
  endtask

  task automatic set_win(input int s, input int w, input int v0, input int v1, input int v2, input int v3);
    int base = (w / 2) * 8 + (w % 2) * 2;
    s_mem[s][base] = 32'(v0); s_mem[s][base + 1] = 32'(v1);
    s_mem[s][base + 4] = 32'(v2); s_mem[s][base + 5] = 32'(v3);
  endtask

  task automatic load_a();
    for (int a = 0; a < 16; a++) begin s_mem[0][a] = 32'(a); s_mem[1][a] = 32'(-a); end
  endtask

  function automatic logic [31:0] ref_pool(input int s, input int a);
    int r = a / 14, c = a % 14;
    longint sum = 0;
    logic signed [31:0] v, m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      v = b_mem[s][(2 * r + k / 2) * 28 + 2 * c + k % 2];
      sum += longint'(v);
      if (k == 0 || v > m) m = v;
    end
    return AVG ? 32'(sum >>> 2) : m;
  endfunction

  initial begin
`ifdef POOL_AVG_EN
    exp_a = '{32'd2, 32'd4, 32'd10, 32'd12, -32'sd3, -32'sd5, -32'sd11, -32'sd13};
    exp_b = '{-32'sd3, 32'd2, 32'd1, -32'sd1, -32'sd8, 32'h7fffffff, 32'h80000000, 32'd0};
`else
    exp_a = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd0, -32'sd2, -32'sd8, -32'sd10};
    exp_b = '{-32'sd1, 32'd5, 32'd9, 32'h7fffffff, -32'sd8, 32'h7fffffff, 32'h80000000, 32'd4};
`endif
    reset = 1'b1; s_start = 1'b0; s_enf = 1'b1; b_start = 1'b0; b_enf = 1'b1;
    load_a();
    for (int s = 0; s < 6; s++) for (int a = 0; a < 784; a++) b_mem[s][a] = $urandom();
    clear_log();
    tick(); tick();
    check("rst_end_to_prev", 64'(s_etp), 64'(1));
    check("rst_strobes", 64'({s_stn, s_ren, s_wen}), 64'(0));
    check("rst_addr_sel", 64'({s_rsel, s_raddr, s_wsel, s_waddr}), 64'(0));
    check("rst_data_out", 64'(s_dout), 64'(0));
    reset = 1'b0;
    tick();

    // Frame A, downstream ready throughout
    clear_log(); s_start = 1'b1; tick(); s_start = 1'b0; rd0 = cyc;
    check("a_read_on", 64'({s_ren, s_etp}), 64'(2'b10));
    wait_pulse("a");
    check_frame("a", exp_a);
    check("a_read_cycles", 64'(rd_cyc), 64'(37));
    check("a_first_wr_latency", 64'(w_cyc[0] - rd0), 64'(5));
    check("a_wr_spacing", 64'(w_cyc[7] - w_cyc[6]), 64'(4));
    check("a_pulse_after_last_wr", 64'(p_cyc > w_cyc[7]), 64'(1));
    tick();
    check("a_pulse_count", 64'(p_n), 64'(1));
    check("a_back_idle", 64'({s_etp, s_stn, s_ren}), 64'(3'b100));

    // Downstream busy: stay in DONE, pulse one cycle after end_from_next rises
    clear_log(); s_enf = 1'b0; s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (60) tick();
    check_frame("hold", exp_a);
    check("hold_no_pulse", 64'(p_n), 64'(0));
    check("hold_done_state", 64'({s_etp, s_ren, s_wen}), 64'(3'b100));
    s_enf = 1'b1; tick();
    check("hold_pulse", 64'(s_stn), 64'(1));
    tick();
    check("hold_pulse_end", 64'({s_etp, s_stn}), 64'(2'b10));
    tick();
    check("hold_idle", 64'({s_etp, s_ren}), 64'(2'b10));

    // Start arriving in DONE is remembered and restarts the read sweep after the hand-off
    s_enf = 1'b0; s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (45) tick();
    s_start = 1'b1; tick(); s_start = 1'b0;
    repeat (3) tick();
    check("pend_waiting", 64'({s_etp, s_stn, s_ren}), 64'(3'b100));
    s_enf = 1'b1; tick();
    check("pend_pulse", 64'(s_stn), 64'(1));
    tick();
    check("pend_read_restart", 64'({s_etp, s_ren, s_rsel, s_raddr}), 64'(7'b0_1_0_0000));
    clear_log();
    wait_pulse("pend");
    check_frame("pend", exp_a);

    // Start in the same cycle as the hand-off pulse goes straight back to READ
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("handoff_read", 64'({s_etp, s_ren}), 64'(2'b01));
    repeat (6) tick();
    reset = 1'b1; clear_log(); tick();
    check("midrst_strobes", 64'({s_ren, s_wen, s_stn}), 64'(0));
    check("midrst_end_to_prev", 64'(s_etp), 64'(1));
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_no_write_or_pulse", 64'({8'(w_n), 8'(p_n)}), 64'(0));
    clear_log(); s_start = 1'b1; tick(); s_start = 1'b0;
    wait_pulse("postrst");
    check_frame("postrst", exp_a);
    check("postrst_read_cycles", 64'(rd_cyc), 64'(37));
    tick();

    // Sign, tie and overflow-prone windows
    set_win(0, 0, -1, -2, -3, -4);
    set_win(0, 1, 1, 2, 3, 5);
    set_win(0, 2, -5, 9, 9, -7);
    set_win(0, 3, 32'h7fffffff, 32'h80000000, 0, 0);
    set_win(1, 0, -8, -8, -8, -8);
    set_win(1, 1, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff);
    set_win(1, 2, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    set_win(1, 3, -3, 4, -1, 2);
    clear_log(); s_start = 1'b1; tick(); s_start = 1'b0;
    wait_pulse("b");
    check_frame("b", exp_b);

    // Default parameters against the reference model
    begin
      int bw = 0, b_rd = 0, b_pulses = 0;
      bit b_done = 1'b0;
      logic [31:0] e;
      b_start = 1'b1;
      for (int n = 0; n < 6000 && !b_done; n++) begin
        @(negedge clk);
        b_start = 1'b0;
        if (!b_etp) b_rd++;
        if (b_wen) begin
          e = (bw < 1176) ? ref_pool(bw / 196, bw % 196) : 32'd0;
          check($sformatf("big_wr%0d", bw), {16'd0, 8'(b_wsel), b_waddr, b_dout},
                {16'd0, 8'(bw / 196), 8'(bw % 196), e});
          bw++;
        end
        if (b_stn) begin b_pulses++; b_done = 1'b1; end
      end
      check("big_finished", 64'(b_done), 64'(1));
      check("big_write_count", 64'(bw), 64'(1176));
      check("big_read_cycles", 64'(b_rd), 64'(4709));
      check("big_pulse_count", 64'(b_pulses), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
